// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the future receiver.
//   DATA_BITS           : bits per character
//   PAR_NONE/EVEN/ODD   : encodings of the PARITY build parameter
//   tx_state_e          : transmitter FSM states
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; tick_o marks the last
// cycle of each bit period.
//   clk_i    : system clock
//   arst_n_i : asynchronous active-low reset (count = 0)
//   clr_i    : hold the count at 0 while asserted
//   tick_o   : high while the count equals CLKS_PER_BIT-1
module uart_baud_cnt #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic clk_i,
   input  logic arst_n_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == LastCnt);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 stop.
//   clk_i    : system clock
//   arst_n_i : asynchronous active-low reset; abandons any frame in progress
//   data_i   : byte to send, sampled only on acceptance
//   valid_i  : byte offered; accepted when ready_o is high at the clock edge
//   ready_o  : idle, a byte can be accepted
//   tx_o     : serial line, idle high
//   busy_o   : frame in progress (inverse of ready_o)
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned PARITY       = PAR_NONE
) (
   input  logic       clk_i,
   input  logic       arst_n_i,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic       busy_o
);

   if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx: CLKS_PER_BIT must be at least 2");
   end

   localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);
   localparam logic       OddPar  = (PARITY == PAR_ODD);
   localparam logic       HasPar  = (PARITY != PAR_NONE);

   tx_state_e  state_q, state_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q, shift_d;
   logic       par_q, par_d;
   logic       tx_q, tx_d;
   logic       ready_q, ready_d;
   logic       busy_q, busy_d;
   logic       tick;

   // Counter is held at zero in idle so every frame starts on a fresh period.
   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk_i   (clk_i),
      .arst_n_i(arst_n_i),
      .clr_i   (state_q == StIdle),
      .tick_o  (tick)
   );

   // tx_d is the line value for the state being entered, so tx_o is a plain
   // flop output and cannot glitch.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tx_d      = tx_q;
      ready_d   = ready_q;

      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (valid_i && ready_q) begin
               shift_d   = data_i;
               par_d     = (^data_i) ^ OddPar;
               bit_idx_d = '0;
               state_d   = StStart;
               tx_d      = 1'b0;
               ready_d   = 1'b0;
            end
         end
         StStart: begin
            if (tick) begin
               state_d = StData;
               tx_d    = shift_q[0];
            end
         end
         StData: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == LastBit) begin
                  if (HasPar) begin
                     state_d = StParity;
                     tx_d    = par_q;
                  end else begin
                     state_d = StStop;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[1];
               end
            end
         end
         StParity: begin
            if (tick) begin
               state_d = StStop;
               tx_d    = 1'b1;
            end
         end
         StStop: begin
            if (tick) begin
               state_d = StIdle;
               ready_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
            ready_d = 1'b1;
         end
      endcase

      busy_d = ~ready_d;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q   <= StIdle;
         bit_idx_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   assign tx_o    = tx_q;
   assign ready_o = ready_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no, even, odd parity) at 4 clocks/bit,
// a frame-level reference model checked every cycle, plus literal expectations.
module tb_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       arst_n = 1'b1;
   logic [2:0] valid = 3'b000;
   logic [7:0] data_v [3];
   logic [2:0] tx, ready, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      uart_tx #(
         .CLKS_PER_BIT(CPB),
         .PARITY      (g)
      ) u_dut (
         .clk_i   (clk),
         .arst_n_i(arst_n),
         .data_i  (data_v[g]),
         .valid_i (valid[g]),
         .ready_o (ready[g]),
         .tx_o    (tx[g]),
         .busy_o  (busy[g])
      );
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame as a bit list, index 0 = first bit on the line.
   function automatic logic [10:0] build_frame(input logic [7:0] b, input int mode);
      logic [10:0] f;
      int ones;
      f = '1;
      ones = 0;
      f[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         f[1+k] = b[k];
         ones += int'(b[k]);
      end
      if (mode == 1) f[9] = logic'(ones % 2);
      if (mode == 2) f[9] = logic'(1 - ones % 2);
      return f;
   endfunction

   // Reference model: a busy countdown and a position within the frame.
   int          m_cnt [3] = '{0, 0, 0};
   int          m_pos [3] = '{0, 0, 0};
   logic [10:0] m_frame [3];

   always @(posedge clk or negedge arst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!arst_n) begin
            m_cnt[i] <= 0;
            m_pos[i] <= 0;
         end else if (m_cnt[i] == 0) begin
            if (valid[i]) begin
               m_frame[i] <= build_frame(data_v[i], i);
               m_cnt[i]   <= (i == 0 ? 10 : 11) * CPB;
               m_pos[i]   <= 0;
            end
         end else begin
            m_cnt[i] <= m_cnt[i] - 1;
            m_pos[i] <= m_pos[i] + 1;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic etx;
         etx = (m_cnt[i] != 0) ? m_frame[i][m_pos[i] / CPB] : 1'b1;
         chk($sformatf("model_tx%0d", i), int'(tx[i]), int'(etx));
         chk($sformatf("model_ready%0d", i), int'(ready[i]), int'(m_cnt[i] == 0));
         chk($sformatf("model_busy%0d", i), int'(busy[i]), int'(m_cnt[i] != 0));
      end
   end

   // Send one byte and check the line at each bit centre against a literal.
   task automatic frame_check(input int idx, input logic [7:0] b, input string bits,
                              input int exp_low, input int inj_cyc, input logic [7:0] inj,
                              input string name);
      int low;
      low = 0;
      @(negedge clk);
      valid[idx]  = 1'b1;
      data_v[idx] = b;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (c == 0) begin
            valid[idx]  = 1'b0;
            data_v[idx] = ~b;
         end
         if (c == inj_cyc) begin
            valid[idx]  = 1'b1;
            data_v[idx] = inj;
         end else if (c == inj_cyc + 1) begin
            valid[idx] = 1'b0;
         end
         if (ready[idx] == 1'b0) low++;
         if (c % CPB == 2 && c / CPB < bits.len())
            chk($sformatf("%s_bit%0d", name, c / CPB), int'(tx[idx]),
                int'(bits[c / CPB] == "1"));
      end
      chk({name, "_ready_low"}, low, exp_low);
      chk({name, "_idle_after"}, int'(tx[idx]), 1);
   endtask

   initial begin
      int   idle_bad;
      int   start2;
      logic txs [100];
      string f1, f2;

      for (int i = 0; i < 3; i++) data_v[i] = 8'h00;
      #2 arst_n = 1'b0;
      repeat (3) @(negedge clk);
      arst_n = 1'b1;

      // Idle after reset.
      idle_bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx != 3'b111 || ready != 3'b111 || busy != 3'b000) idle_bad++;
      end
      chk("idle_100_cycles", idle_bad, 0);

      frame_check(0, 8'hA5, "0101001011", 40, -1, 8'h00, "a5_nopar");
      frame_check(1, 8'h07, "01110000011", 44, -1, 8'h00, "07_even");
      frame_check(2, 8'h00, "00000000011", 44, -1, 8'h00, "00_odd");
      frame_check(0, 8'h3C, "0001111001", 40, 10, 8'hFF, "3c_drop_ff");

      // Back-to-back: second byte offered in the first ready cycle.
      f1 = "0100000001";
      f2 = "0000000011";
      start2 = -1;
      @(negedge clk);
      valid[0]  = 1'b1;
      data_v[0] = 8'h01;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         txs[c] = tx[0];
         if (c == 0) begin
            valid[0] = 1'b0;
         end else if (start2 < 0 && ready[0]) begin
            valid[0]  = 1'b1;
            data_v[0] = 8'h80;
            start2    = c + 1;
         end else if (c == start2) begin
            valid[0] = 1'b0;
         end
      end
      chk("b2b_second_start_cycle", start2, 41);
      for (int k = 0; k < 10; k++)
         chk($sformatf("b2b_f1_bit%0d", k), int'(txs[k * CPB + 2]), int'(f1[k] == "1"));
      chk("b2b_gap_high", int'(txs[40]), 1);
      if (start2 >= 0 && start2 + 39 < 100)
         for (int k = 0; k < 10; k++)
            chk($sformatf("b2b_f2_bit%0d", k), int'(txs[start2 + k * CPB + 2]),
                int'(f2[k] == "1"));

      // Reset in the middle of data bit 3 of 0x00.
      @(negedge clk);
      valid[0]  = 1'b1;
      data_v[0] = 8'h00;
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (17) @(negedge clk);
      chk("rst_mid_busy_before", int'(ready[0]), 0);
      #1 arst_n = 1'b0;
      #1;
      chk("rst_async_tx", int'(tx[0]), 1);
      chk("rst_async_ready", int'(ready[0]), 1);
      chk("rst_async_busy", int'(busy[0]), 0);
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      frame_check(0, 8'h55, "0101010101", 40, -1, 8'h00, "55_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
